// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard control slice.
// Holds the controller state enum, parameter defaults and control bundle.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FAULT  = 2'd2
  } hz_state_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 16;
  localparam int WAIT_W      = 10;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
    logic mem_fault;
  } hz_ctl_t;

  function automatic hz_ctl_t ctl_normal();
    hz_ctl_t c;
    c = '0;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.id_ex_write  = 1'b1;
    c.ex_mem_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones, never wraps.
// Ports: clock, reset (async high), enable, count[CNT_W-1:0].
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (enable && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, dmem freeze,
// memory-timeout fault, plus stall/flush performance counters.
// Ports: clock, reset (async high), ID/EX hazard inputs, dmem_req/ready,
// stage write enables, flush/bubble controls, mem_fault, counters.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_e         state;
  hz_state_e         state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait;
  logic              load_use;
  logic              wait_last;
  hz_ctl_t           ctl;
  logic              stall_en;
  logic              flush_en;

  assign mem_wait = dmem_req && !dmem_ready;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // True on the TIMEOUT-th consecutive wait cycle.
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= RUN;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        // TIMEOUT=1 faults on the first wait cycle.
        if (mem_wait)
          state_nx = wait_last ? FAULT : FREEZE;
      end
      FREEZE: begin
        if (!mem_wait)
          state_nx = RUN;
        else if (wait_last)
          state_nx = FAULT;
      end
      FAULT:   state_nx = FAULT;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (state_nx == RUN)
      wait_cnt <= '0;
    else if (mem_wait && (state != FAULT))
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    ctl = ctl_normal();
    if (reset) begin
      ctl               = '0;
      ctl.if_id_flush   = 1'b1;
      ctl.id_ex_bubble  = 1'b1;
      ctl.mem_wb_bubble = 1'b1;
    end else if (state == FAULT) begin
      ctl               = '0;
      ctl.id_ex_bubble  = 1'b1;
      ctl.mem_wb_bubble = 1'b1;
      ctl.mem_fault     = 1'b1;
    end else if (mem_wait) begin
      ctl               = '0;
      ctl.mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      ctl.pc_write     = 1'b0;
      ctl.if_id_write  = 1'b0;
      ctl.id_ex_bubble = 1'b1;
    end
  end

  assign pc_write      = ctl.pc_write;
  assign if_id_write   = ctl.if_id_write;
  assign id_ex_write   = ctl.id_ex_write;
  assign ex_mem_write  = ctl.ex_mem_write;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_bubble  = ctl.id_ex_bubble;
  assign mem_wb_bubble = ctl.mem_wb_bubble;
  assign mem_fault     = ctl.mem_fault;

  // FAULT also drops pc_write but is not a counted stall.
  assign stall_en = !reset && !ctl.pc_write && (state != FAULT);
  assign flush_en = !reset && ctl.if_id_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset  (reset),
    .enable (stall_en),
    .count  (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .reset  (reset),
    .enable (flush_en),
    .count  (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: default instance plus a small
// instance (TIMEOUT=4, CNT_W=4) driven by the same stimulus.
module tb_hazard_controller;
  import pipeline_ctrl_pkg::*;

  localparam logic [7:0] NORM = 8'b1111_0000;
  localparam logic [7:0] LU   = 8'b0011_0100;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] MW   = 8'b0000_0010;
  localparam logic [7:0] FLT  = 8'b0000_0111;
  localparam logic [7:0] RST  = 8'b0000_1110;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_mem_read, ex_branch_taken;
  logic       dmem_req, dmem_ready;

  logic pc_d, ifw_d, iflush_d, idw_d, exw_d, idb_d, mwb_d, flt_d;
  logic pc_s, ifw_s, iflush_s, idw_s, exw_s, idb_s, mwb_s, flt_s;
  logic [15:0] stall_d, flush_d;
  logic [3:0]  stall_s, flush_s;
  logic [7:0]  obs_d, obs_s, exp;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  assign obs_d = {pc_d, ifw_d, idw_d, exw_d, iflush_d, idb_d, mwb_d, flt_d};
  assign obs_s = {pc_s, ifw_s, idw_s, exw_s, iflush_s, idb_s, mwb_s, flt_s};

  hazard_controller dut_d (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_d), .if_id_write(ifw_d), .if_id_flush(iflush_d),
    .id_ex_write(idw_d), .ex_mem_write(exw_d),
    .id_ex_bubble(idb_d), .mem_wb_bubble(mwb_d), .mem_fault(flt_d),
    .stall_cycles(stall_d), .flush_count(flush_d)
  );

  hazard_controller #(.TIMEOUT(4), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_s), .if_id_write(ifw_s), .if_id_flush(iflush_s),
    .id_ex_write(idw_s), .ex_mem_write(exw_s),
    .id_ex_bubble(idb_s), .mem_wb_bubble(mwb_s), .mem_fault(flt_s),
    .stall_cycles(stall_s), .flush_count(flush_s)
  );

  // {rs1, rs2, u1, u2, rd, mem_read, req, ready, expected ctl}
  logic [27:0] tbl [8] = '{
    {5'd5, 5'd5,  1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, NORM},
    {5'd7, 5'd3,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, LU},
    {5'd7, 5'd3,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, NORM},
    {5'd9, 5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, NORM},
    {5'd1, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, LU},
    {5'd2, 5'd4,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, NORM},
    {5'd2, 5'd4,  1'b1, 1'b1, 5'd6,  1'b0, 1'b0, 1'b1, NORM},
    {5'd8, 5'd4,  1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 1'b1, LU}
  };

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr,
                       input logic bt, input logic rq, input logic rdy,
                       input logic [7:0] e);
    id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr;
    ex_branch_taken = bt;
    dmem_req = rq; dmem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, RST);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || obs_d !== exp) begin
      errors++;
      $display("FAIL reset_ctl: got %b/%b want %b", obs_s, obs_d, exp);
    end
    @(posedge clock); #1;
    checks++;
    if (stall_d !== 0 || flush_d !== 0 || stall_s !== 0 || flush_s !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0",
               stall_d, flush_d, stall_s, flush_s);
    end
    @(negedge clock);
    idle();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clock);
    drive(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, LU);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || obs_d !== exp) begin
      errors++;
      $display("FAIL load_use_ctl: got %b/%b want %b", obs_s, obs_d, exp);
    end
    @(posedge clock); #1;
    checks++;
    if (stall_d !== 16'd1 || stall_s !== 4'd1 || flush_d !== 0) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d/%0d/%0d want 1/1/0",
               stall_d, stall_s, flush_d);
    end
    @(negedge clock);
    drive(5'd0, 5'd5, 0, 1, 5'd0, 0, 0, 0, 0, NORM);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || obs_d !== exp) begin
      errors++;
      $display("FAIL load_use_after: got %b/%b want %b", obs_s, obs_d, exp);
    end
  endtask

  task automatic test_patterns();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive(tbl[i][27:23], tbl[i][22:18], tbl[i][17], tbl[i][16],
            tbl[i][15:11], tbl[i][10], 1'b0, tbl[i][9], tbl[i][8],
            tbl[i][7:0]);
      #2;
      exp = exp_q.pop_front();
      checks++;
      if (obs_s !== exp || obs_d !== exp) begin
        errors++;
        $display("FAIL pattern_%0d: got %b/%b want %b", i, obs_s, obs_d, exp);
      end
    end
    @(posedge clock); #1;
    checks++;
    if (stall_d !== 16'd3 || flush_d !== 16'd0) begin
      errors++;
      $display("FAIL pattern_cnt: got %0d/%0d want 3/0", stall_d, flush_d);
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clock);
    drive(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, BR);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || obs_d !== exp) begin
      errors++;
      $display("FAIL branch_ctl: got %b/%b want %b", obs_s, obs_d, exp);
    end
    @(posedge clock); #1;
    checks++;
    if (flush_d !== 16'd1 || stall_d !== 16'd0 || flush_s !== 4'd1) begin
      errors++;
      $display("FAIL branch_cnt: got flush %0d stall %0d want 1/0",
               flush_d, stall_d);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 0, MW);
      #2;
      exp = exp_q.pop_front();
      checks++;
      if (obs_s !== exp || obs_d !== exp) begin
        errors++;
        $display("FAIL freeze_ctl_%0d: got %b/%b want %b",
                 i, obs_s, obs_d, exp);
      end
      @(posedge clock); #1;
      checks++;
      if (dut_d.state !== FREEZE || dut_s.state !== FREEZE) begin
        errors++;
        $display("FAIL freeze_state_%0d: got %0d/%0d want %0d",
                 i, dut_d.state, dut_s.state, FREEZE);
      end
    end
    @(negedge clock);
    drive(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 1, BR);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || obs_d !== exp) begin
      errors++;
      $display("FAIL freeze_release: got %b/%b want %b", obs_s, obs_d, exp);
    end
    @(posedge clock); #1;
    checks++;
    if (dut_d.state !== RUN || stall_d !== 16'd3 || flush_d !== 16'd1
        || flt_s !== 1'b0) begin
      errors++;
      $display("FAIL freeze_end: got state %0d stall %0d flush %0d want 0/3/1",
               dut_d.state, stall_d, flush_d);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, MW);
      #2;
      exp = exp_q.pop_front();
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL timeout_wait_%0d: got %b want %b", i, obs_s, exp);
      end
      @(posedge clock);
    end
    @(negedge clock);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, FLT);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || obs_d !== MW) begin
      errors++;
      $display("FAIL timeout_fault: got %b/%b want %b/%b",
               obs_s, obs_d, exp, MW);
    end
    @(posedge clock);
    @(negedge clock);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, FLT);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp || stall_s !== 4'd4) begin
      errors++;
      $display("FAIL timeout_sticky: got %b stall %0d want %b stall 4",
               obs_s, stall_s, exp);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (dut_s.state !== RUN || stall_s !== 0 || flush_s !== 0
        || flt_s !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset: got state %0d stall %0d fault %b want 0/0/0",
               dut_s.state, stall_s, flt_s);
    end
    #1;
    reset = 1'b0;
    @(negedge clock);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NORM);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (obs_s !== exp) begin
      errors++;
      $display("FAIL timeout_post: got %b want %b", obs_s, exp);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      drive(5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, LU);
      #2;
      exp = exp_q.pop_front();
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL sat_ctl_%0d: got %b want %b", i, obs_s, exp);
      end
      @(negedge clock);
      idle();
    end
    @(posedge clock); #1;
    checks++;
    if (stall_s !== 4'd15 || stall_d !== 16'd20) begin
      errors++;
      $display("FAIL sat_stall: got %0d/%0d want 15/20", stall_s, stall_d);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, BR);
      #2;
      exp = exp_q.pop_front();
      @(posedge clock); #1;
      checks++;
      if (obs_d !== exp || flush_d !== 16'(i + 1)
          || flush_s !== 4'((i < 15) ? i + 1 : 15)) begin
        errors++;
        $display("FAIL b2b_flush_%0d: got %b %0d/%0d want %b %0d/%0d",
                 i, obs_d, flush_d, flush_s, exp, i + 1,
                 (i < 15) ? i + 1 : 15);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_patterns();
    test_branch();
    test_freeze();
    test_timeout();
    test_saturate();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
